// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_HUNT} state_t;

  // A zero length would never complete a window, so it is treated as one bit.
  function automatic int clamp_len(input int len, input int max_w);
    if (len < 1)     return 1;
    if (len > max_w) return max_w;
    return len;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that outranks the increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_cnt <= '0;
    else if (clr)         r_cnt <= '0;
    else if (inc && !sat) r_cnt <= r_cnt + W'(1);
  end

  assign cnt = r_cnt;
  assign sat = &r_cnt;

endmodule

// File: rtl/seq_detector_param.sv
// Run-time programmable serial bit-pattern detector with overlap control,
// valid qualifier and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PATTERN_W = 4,
  parameter int CNT_W     = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           clear,
  input  logic                           in_valid,
  input  logic                           in_value,
  input  logic [PATTERN_W-1:0]           cfg_pattern,
  input  logic [$clog2(PATTERN_W+1)-1:0] cfg_len,
  input  logic                           cfg_overlap,
  output logic                           out_value,
  output logic [CNT_W-1:0]               match_count,
  output logic                           count_sat
);

  localparam int LW = $clog2(PATTERN_W+1);

  state_t               r_state;
  logic [PATTERN_W-1:0] r_hist, r_pat;
  logic [LW-1:0]        r_fill, r_len;
  logic                 r_overlap, r_out;

  logic [PATTERN_W:0]   w_nh, w_one_sh;
  logic [PATTERN_W-1:0] w_mask;
  logic [LW:0]          w_fill_inc;
  logic                 w_active, w_match;

  assign w_nh       = {r_hist, in_value};
  assign w_one_sh   = (PATTERN_W+1)'(1) << r_len;
  assign w_mask     = PATTERN_W'(w_one_sh - (PATTERN_W+1)'(1));
  assign w_fill_inc = (LW+1)'(r_fill) + (LW+1)'(1);
  assign w_active   = enable && in_valid && (r_state != S_IDLE);
  // fill+1 >= len is the same test as fill >= len-1 without underflow.
  assign w_match    = w_active && (w_fill_inc >= (LW+1)'(r_len)) &&
                      (((w_nh[PATTERN_W-1:0] ^ r_pat) & w_mask) == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_hist    <= '0;
      r_fill    <= '0;
      r_pat     <= '0;
      r_len     <= LW'(1);
      r_overlap <= 1'b0;
      r_out     <= 1'b0;
    end else if (!enable) begin
      r_state <= S_IDLE;
      r_hist  <= '0;
      r_fill  <= '0;
      r_out   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pat     <= cfg_pattern;
          r_len     <= LW'(clamp_len(int'(cfg_len), PATTERN_W));
          r_overlap <= cfg_overlap;
          r_state   <= S_FILL;
          r_out     <= 1'b0;
        end
        default: begin
          r_out <= w_match;
          if (in_valid) begin
            r_hist <= w_nh[PATTERN_W-1:0];
            // Non-overlap restarts the window so no matched bit is reused.
            if (w_match && !r_overlap) begin
              r_fill  <= '0;
              r_state <= S_FILL;
            end else if (w_fill_inc >= (LW+1)'(r_len)) begin
              r_fill  <= r_len;
              r_state <= S_HUNT;
            end else begin
              r_fill  <= w_fill_inc[LW-1:0];
              r_state <= S_FILL;
            end
          end
        end
      endcase
    end
  end

  assign out_value = r_out;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear),
    .inc     (w_match),
    .cnt     (match_count),
    .sat     (count_sat)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param (PATTERN_W=4, CNT_W=2).
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset_n, enable, clear, in_valid, in_value, cfg_overlap;
  logic [3:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic       out_value, count_sat;
  logic [1:0] match_count;

  int n_chk  = 0;
  int n_fail = 0;

  seq_detector_param #(.PATTERN_W(4), .CNT_W(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_value    (in_value),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .out_value   (out_value),
    .match_count (match_count),
    .count_sat   (count_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of input, then check out_value just after the edge.
  task automatic step(input string tag, input logic v, input logic b, input logic exp_out);
    in_valid = v;
    in_value = b;
    @(posedge clk); #1;
    chk(tag, {31'd0, out_value}, {31'd0, exp_out});
  endtask

  task automatic idle_clear();
    enable = 1'b0; clear = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("cleared_cnt", {30'd0, match_count}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; clear = 1'b0; in_valid = 1'b0; in_value = 1'b0;
    cfg_pattern = 4'b0000; cfg_len = 3'd0; cfg_overlap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {31'd0, out_value}, 32'd0);
    chk("rst_cnt", {30'd0, match_count}, 32'd0);
    chk("rst_sat", {31'd0, count_sat}, 32'd0);
    reset_n = 1'b1;

    // len=3, pat=111, overlap: 0,1,1,1,1,0 -> pulses after bits 4 and 5
    cfg_pattern = 4'b0111; cfg_len = 3'd3; cfg_overlap = 1'b1; enable = 1'b1;
    step("ov_arm", 1'b0, 1'b0, 1'b0);
    step("ov_b1", 1'b1, 1'b0, 1'b0);
    step("ov_b2", 1'b1, 1'b1, 1'b0);
    step("ov_b3", 1'b1, 1'b1, 1'b0);
    step("ov_b4", 1'b1, 1'b1, 1'b1);
    step("ov_b5", 1'b1, 1'b1, 1'b1);
    step("ov_b6", 1'b1, 1'b0, 1'b0);
    chk("ov_cnt", {30'd0, match_count}, 32'd2);
    idle_clear();

    // same pattern, no overlap: six 1s -> pulses after bits 3 and 6
    cfg_overlap = 1'b0; enable = 1'b1;
    step("nov_arm", 1'b0, 1'b0, 1'b0);
    step("nov_b1", 1'b1, 1'b1, 1'b0);
    step("nov_b2", 1'b1, 1'b1, 1'b0);
    step("nov_b3", 1'b1, 1'b1, 1'b1);
    step("nov_b4", 1'b1, 1'b1, 1'b0);
    step("nov_b5", 1'b1, 1'b1, 1'b0);
    step("nov_b6", 1'b1, 1'b1, 1'b1);
    chk("nov_cnt", {30'd0, match_count}, 32'd2);
    idle_clear();

    // len=4, pat=1011 with a three-cycle valid gap
    cfg_pattern = 4'b1011; cfg_len = 3'd4; cfg_overlap = 1'b1; enable = 1'b1;
    step("gap_arm", 1'b0, 1'b0, 1'b0);
    step("gap_b1", 1'b1, 1'b1, 1'b0);
    step("gap_b2", 1'b1, 1'b0, 1'b0);
    step("gap_g1", 1'b0, 1'b1, 1'b0);
    step("gap_g2", 1'b0, 1'b1, 1'b0);
    step("gap_g3", 1'b0, 1'b1, 1'b0);
    step("gap_b3", 1'b1, 1'b1, 1'b0);
    step("gap_b4", 1'b1, 1'b1, 1'b1);
    chk("gap_cnt", {30'd0, match_count}, 32'd1);

    // asynchronous reset between clock edges
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out", {31'd0, out_value}, 32'd0);
    chk("arst_cnt", {30'd0, match_count}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1; enable = 1'b0;
    @(posedge clk); #1;

    // len=1, pat=1: saturating count then clear alongside a match
    cfg_pattern = 4'b0001; cfg_len = 3'd1; cfg_overlap = 1'b1; enable = 1'b1;
    step("sat_arm", 1'b0, 1'b0, 1'b0);
    step("sat_b1", 1'b1, 1'b1, 1'b1);
    chk("sat_c1", {30'd0, match_count}, 32'd1);
    chk("sat_s1", {31'd0, count_sat}, 32'd0);
    step("sat_b2", 1'b1, 1'b1, 1'b1);
    chk("sat_c2", {30'd0, match_count}, 32'd2);
    step("sat_b3", 1'b1, 1'b1, 1'b1);
    chk("sat_c3", {30'd0, match_count}, 32'd3);
    chk("sat_s3", {31'd0, count_sat}, 32'd1);
    step("sat_b4", 1'b1, 1'b1, 1'b1);
    chk("sat_c4", {30'd0, match_count}, 32'd3);
    step("sat_b5", 1'b1, 1'b1, 1'b1);
    chk("sat_c5", {30'd0, match_count}, 32'd3);
    chk("sat_s5", {31'd0, count_sat}, 32'd1);
    clear = 1'b1;
    step("clr_out", 1'b1, 1'b1, 1'b1);
    clear = 1'b0;
    chk("clr_cnt", {30'd0, match_count}, 32'd0);
    chk("clr_sat", {31'd0, count_sat}, 32'd0);

    // len=0 clamps to 1; config changes while enabled are ignored
    enable = 1'b0;
    @(posedge clk); #1;
    cfg_pattern = 4'b0000; cfg_len = 3'd0; enable = 1'b1;
    step("cfg_arm", 1'b0, 1'b0, 1'b0);
    cfg_pattern = 4'b1111; cfg_len = 3'd1;
    step("cfg_old0", 1'b1, 1'b0, 1'b1);
    step("cfg_old1", 1'b1, 1'b1, 1'b0);
    enable = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    step("cfg_rearm", 1'b0, 1'b0, 1'b0);
    step("cfg_new1", 1'b1, 1'b1, 1'b1);
    step("cfg_new0", 1'b1, 1'b0, 1'b0);
    chk("cfg_cnt", {30'd0, match_count}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
